// File: rtl/nfc_ssp_packer_pkg.sv
// Shared definitions for the NFC SSP packer slice.
// Holds the serializer state encodings, the byte width used on the SSP
// link and a helper that left-aligns a partially collected byte.
package nfc_ssp_packer_pkg;

   localparam int SSP_BYTE_W = 8;

   typedef logic [SSP_BYTE_W-1:0] ssp_byte_t;

   // Serializer state encodings, kept as plain constants so the same
   // values can be shared with the older hi_* mode sources.
   localparam logic [0:0] SSP_IDLE  = 1'b0;
   localparam logic [0:0] SSP_SHIFT = 1'b1;

   // Move the n most recent bits of data_in (held in its low bits) up to the
   // MSB end, filling the LSB side with zeros. n is 1..7.
   function automatic ssp_byte_t left_align(input ssp_byte_t data_in, input logic [2:0] n);
      logic [3:0] shift;
      shift = 4'd8 - {1'b0, n};
      return data_in << shift;
   endfunction

endpackage

// File: rtl/nfc_ssp_packer_fifo.sv
// ssp_byte_fifo: small byte FIFO between the bit packer and the SSP
// serializer.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   clr              synchronous clear of pointers and level
//   push, wdata      write request and byte; accepted when not full or when
//                    a pop happens in the same cycle
//   pop, rdata       read request; rdata always shows the oldest entry
//   full, empty      occupancy flags derived from the registered level
//   level            number of occupied entries
module ssp_byte_fifo
   import nfc_ssp_packer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr,
   input  logic                          push,
   input  ssp_byte_t                     wdata,
   input  logic                          pop,
   output ssp_byte_t                     rdata,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

   ssp_byte_t         mem_q [FIFO_DEPTH];
   ssp_byte_t         mem_d [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              wr_en, rd_en;

   assign full  = (level_q == DEPTH_L);
   assign empty = (level_q == '0);
   assign rdata = mem_q[rd_ptr_q];
   assign level = level_q;

   // Pointers wrap naturally because the depth is a power of two. A pop
   // frees a slot in the same cycle, so a full FIFO can still take a push.
   always_comb begin
      rd_en    = pop & ~empty;
      wr_en    = push & (~full | rd_en);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_en, rd_en})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/nfc_ssp_packer.sv
// nfc_ssp_packer: packs demodulated bits MSB-first into bytes, buffers them
// in a small FIFO and shifts them out over the SSP link to the ARM.
// Ports:
//   ck_1356meg, nreset   13.56 MHz clock, asynchronous active-low reset
//   enable               low clears all state synchronously
//   bit_in, bit_stb      demodulated bit and its one-cycle strobe
//   flush                emit a partial byte, zero-padded on the LSB side
//   ssp_clk              divided clock, low first half, high second half
//   ssp_frame            high for the period carrying bit 7 of a byte
//   ssp_din              serial data, MSB first, changes on ssp_clk falls
//   overflow             sticky, a byte was dropped on a full FIFO
//   fifo_level           number of bytes waiting in the FIFO
module nfc_ssp_packer
   import nfc_ssp_packer_pkg::*;
#(
   parameter int CLK_DIV    = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          ck_1356meg,
   input  logic                          nreset,
   input  logic                          enable,
   input  logic                          bit_in,
   input  logic                          bit_stb,
   input  logic                          flush,
   output logic                          ssp_clk,
   output logic                          ssp_frame,
   output logic                          ssp_din,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

   ssp_byte_t      sr_q, sr_d, sr_stb, push_data, fifo_rdata;
   logic [2:0]     cnt_q, cnt_d, cnt_inc;
   logic [DW-1:0]  div_q, div_d;
   logic           ssp_clk_q, ssp_clk_d;
   logic [0:0]     state_q, state_d;
   logic [2:0]     bcnt_q, bcnt_d;
   logic [6:0]     shreg_q, shreg_d;
   logic           din_q, din_d, frame_q, frame_d;
   logic           overflow_q, overflow_d;
   logic           push, pop, tick, fifo_full, fifo_empty;

   // Packer. A same-cycle bit counts towards a flush; when that bit completes
   // the byte the normal push wins and the flush has nothing left to emit.
   always_comb begin
      sr_stb    = bit_stb ? {sr_q[6:0], bit_in} : sr_q;
      cnt_inc   = cnt_q + {2'b00, bit_stb};
      sr_d      = sr_stb;
      cnt_d     = cnt_inc;
      push      = 1'b0;
      push_data = sr_stb;
      if (bit_stb && cnt_q == 3'd7) begin
         push = 1'b1;
      end else if (flush && cnt_inc != 3'd0) begin
         push      = 1'b1;
         push_data = left_align(sr_stb, cnt_inc);
         sr_d      = '0;
         cnt_d     = 3'd0;
      end
      if (!enable) begin
         push  = 1'b0;
         sr_d  = '0;
         cnt_d = 3'd0;
      end
   end

   // Divider. The registered ssp_clk tracks div, so it falls exactly on the
   // tick edge where the serializer updates data.
   always_comb begin
      tick      = enable && (div_q == DIV_LAST);
      div_d     = '0;
      if (enable && !tick) begin
         div_d = div_q + DW'(1);
      end
      ssp_clk_d = enable && (div_d >= DIV_HALF);
   end

   // Serializer. shreg holds the bits not yet presented; bit 7 goes straight
   // to ssp_din when a byte is loaded.
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      shreg_d = shreg_q;
      din_d   = din_q;
      frame_d = frame_q;
      pop     = 1'b0;
      if (!enable) begin
         state_d = SSP_IDLE;
         bcnt_d  = 3'd0;
         shreg_d = '0;
         din_d   = 1'b0;
         frame_d = 1'b0;
      end else if (tick) begin
         if (state_q == SSP_SHIFT && bcnt_q != 3'd7) begin
            bcnt_d  = bcnt_q + 3'd1;
            din_d   = shreg_q[6];
            shreg_d = {shreg_q[5:0], 1'b0};
            frame_d = 1'b0;
         end else if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = SSP_SHIFT;
            bcnt_d  = 3'd0;
            din_d   = fifo_rdata[7];
            shreg_d = fifo_rdata[6:0];
            frame_d = 1'b1;
         end else begin
            state_d = SSP_IDLE;
            din_d   = 1'b0;
            frame_d = 1'b0;
         end
      end
   end

   always_comb begin
      overflow_d = enable && (overflow_q || (push && fifo_full && !pop));
   end

   always_ff @(posedge ck_1356meg or negedge nreset) begin
      if (!nreset) begin
         sr_q       <= '0;
         cnt_q      <= 3'd0;
         div_q      <= '0;
         ssp_clk_q  <= 1'b0;
         state_q    <= SSP_IDLE;
         bcnt_q     <= 3'd0;
         shreg_q    <= '0;
         din_q      <= 1'b0;
         frame_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         ssp_clk_q  <= ssp_clk_d;
         state_q    <= state_d;
         bcnt_q     <= bcnt_d;
         shreg_q    <= shreg_d;
         din_q      <= din_d;
         frame_q    <= frame_d;
         overflow_q <= overflow_d;
      end
   end

   ssp_byte_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (ck_1356meg),
      .rst_n (nreset),
      .clr   (!enable),
      .push  (push),
      .wdata (push_data),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign ssp_clk   = ssp_clk_q;
   assign ssp_frame = frame_q;
   assign ssp_din   = din_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_nfc_ssp_packer.sv
// Directed bench for nfc_ssp_packer with CLK_DIV=8, FIFO_DEPTH=4.
// A receiver process samples {ssp_frame, ssp_din} on each rising ssp_clk,
// like the ARM does; each test task decodes that record and checks it
// against hand-computed values.
module tb_nfc_ssp_packer;

   logic       ck_1356meg = 1'b0;
   logic       nreset = 1'b0;
   logic       enable = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_stb = 1'b0;
   logic       flush = 1'b0;
   logic       ssp_clk, ssp_frame, ssp_din, overflow;
   logic [2:0] fifo_level;

   int         n_cmp = 0;
   int         n_fail = 0;
   logic [1:0] wire_q[$];

   always #5 ck_1356meg = ~ck_1356meg;

   nfc_ssp_packer #(
      .CLK_DIV    (8),
      .FIFO_DEPTH (4)
   ) dut (
      .ck_1356meg (ck_1356meg),
      .nreset     (nreset),
      .enable     (enable),
      .bit_in     (bit_in),
      .bit_stb    (bit_stb),
      .flush      (flush),
      .ssp_clk    (ssp_clk),
      .ssp_frame  (ssp_frame),
      .ssp_din    (ssp_din),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   // Receiver: one {frame, din} entry per ssp_clk period.
   always @(posedge ssp_clk) begin
      #1;
      wire_q.push_back({ssp_frame, ssp_din});
   end

   // Hard stop in case something stalls outside the bounded waits.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog got timeout exp finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge ck_1356meg);
      #1;
   endtask

   task automatic reset_dut();
      nreset  = 1'b0;
      enable  = 1'b0;
      bit_stb = 1'b0;
      bit_in  = 1'b0;
      flush   = 1'b0;
      step();
      step();
      nreset = 1'b1;
      enable = 1'b1;
   endtask

   // Strobe the n low bits of v, MSB first, one bit per cycle.
   task automatic send_bits(input logic [7:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         bit_stb = 1'b1;
         bit_in  = v[n-1-i];
         step();
      end
      bit_stb = 1'b0;
      bit_in  = 1'b0;
   endtask

   // Wait until the receiver holds a frame plus need-1 following periods.
   task automatic wait_wire(input int need, output int f, output bit ok);
      int idx;
      ok = 1'b0;
      f  = 0;
      for (int c = 0; c < 2000 && !ok; c++) begin
         @(negedge ck_1356meg);
         idx = -1;
         for (int i = 0; i < wire_q.size(); i++) begin
            if (idx < 0 && wire_q[i][1]) idx = i;
         end
         if (idx >= 0 && wire_q.size() >= idx + need) begin
            ok = 1'b1;
            f  = idx;
         end
      end
   endtask

   function automatic logic [7:0] wire_byte(input int idx);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[7-i] = wire_q[idx+i][0];
      return b;
   endfunction

   function automatic logic [7:0] wire_frames(input int idx);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[7-i] = wire_q[idx+i][1];
      return b;
   endfunction

   task automatic test_reset();
      nreset = 1'b0;
      enable = 1'b0;
      step();
      n_cmp++;
      if ({ssp_clk, ssp_frame, ssp_din, overflow, fifo_level} !== 7'h00) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs got %h exp %h", {ssp_clk, ssp_frame, ssp_din, overflow, fifo_level}, 7'h00);
      end
      nreset = 1'b1;
      enable = 1'b1;
      step(); step(); step();
      n_cmp++;
      if (ssp_clk !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL div_low_half got %b exp %b", ssp_clk, 1'b0);
      end
      step();
      n_cmp++;
      if (ssp_clk !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL div_high_half got %b exp %b", ssp_clk, 1'b1);
      end
      step(); step(); step(); step();
      n_cmp++;
      if (ssp_clk !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL div_wrap got %b exp %b", ssp_clk, 1'b0);
      end
   endtask

   task automatic test_byte_a5();
      int f;
      bit ok;
      reset_dut();
      wire_q.delete();
      send_bits(8'hA5, 8);
      n_cmp++;
      if (fifo_level !== 3'd1) begin
         n_fail++;
         $display("[TB] FAIL a5_level got %0d exp %0d", fifo_level, 1);
      end
      wait_wire(9, f, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("[TB] FAIL a5_timeout got %0d exp %0d", wire_q.size(), 9);
      end else begin
         n_cmp++;
         if (wire_byte(f) !== 8'hA5) begin
            n_fail++;
            $display("[TB] FAIL a5_data got %h exp %h", wire_byte(f), 8'hA5);
         end
         n_cmp++;
         if (wire_frames(f) !== 8'h80) begin
            n_fail++;
            $display("[TB] FAIL a5_frame got %h exp %h", wire_frames(f), 8'h80);
         end
         n_cmp++;
         if (wire_q[f+8] !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL a5_idle_after got %b exp %b", wire_q[f+8], 2'b00);
         end
      end
      n_cmp++;
      if (fifo_level !== 3'd0) begin
         n_fail++;
         $display("[TB] FAIL a5_level_drain got %0d exp %0d", fifo_level, 0);
      end
   endtask

   task automatic test_flush();
      int f;
      bit ok;
      reset_dut();
      wire_q.delete();
      send_bits(8'h06, 3);
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_cmp++;
      if (fifo_level !== 3'd1) begin
         n_fail++;
         $display("[TB] FAIL flush_push got %0d exp %0d", fifo_level, 1);
      end
      wait_wire(9, f, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("[TB] FAIL flush_timeout got %0d exp %0d", wire_q.size(), 9);
      end else begin
         n_cmp++;
         if ({wire_byte(f), wire_frames(f), wire_q[f+8]} !== {8'hC0, 8'h80, 2'b00}) begin
            n_fail++;
            $display("[TB] FAIL flush_c0 got %h exp %h", {wire_byte(f), wire_frames(f), wire_q[f+8]}, {8'hC0, 8'h80, 2'b00});
         end
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_cmp++;
      if (fifo_level !== 3'd0) begin
         n_fail++;
         $display("[TB] FAIL flush_empty_noop got %0d exp %0d", fifo_level, 0);
      end
      // Flush with a same-cycle bit (101 -> A0), then flush on the bit that
      // completes 0x96, which must give exactly one push.
      wire_q.delete();
      send_bits(8'h02, 2);
      bit_stb = 1'b1;
      bit_in  = 1'b1;
      flush   = 1'b1;
      step();
      flush   = 1'b0;
      send_bits(8'h4B, 7);
      bit_stb = 1'b1;
      bit_in  = 1'b0;
      flush   = 1'b1;
      step();
      bit_stb = 1'b0;
      flush   = 1'b0;
      wait_wire(17, f, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("[TB] FAIL flush_stb_timeout got %0d exp %0d", wire_q.size(), 17);
      end else begin
         n_cmp++;
         if ({wire_byte(f), wire_byte(f+8)} !== 16'hA096) begin
            n_fail++;
            $display("[TB] FAIL flush_stb_data got %h exp %h", {wire_byte(f), wire_byte(f+8)}, 16'hA096);
         end
         n_cmp++;
         if (wire_q[f+16] !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL flush_single_push got %b exp %b", wire_q[f+16], 2'b00);
         end
      end
   endtask

   task automatic test_back_to_back();
      int f;
      bit ok;
      reset_dut();
      wire_q.delete();
      send_bits(8'h3C, 8);
      send_bits(8'hFF, 8);
      wait_wire(17, f, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("[TB] FAIL b2b_timeout got %0d exp %0d", wire_q.size(), 17);
      end else begin
         n_cmp++;
         if ({wire_byte(f), wire_byte(f+8)} !== 16'h3CFF) begin
            n_fail++;
            $display("[TB] FAIL b2b_data got %h exp %h", {wire_byte(f), wire_byte(f+8)}, 16'h3CFF);
         end
         n_cmp++;
         if ({wire_frames(f), wire_frames(f+8)} !== 16'h8080) begin
            n_fail++;
            $display("[TB] FAIL b2b_frames got %h exp %h", {wire_frames(f), wire_frames(f+8)}, 16'h8080);
         end
         n_cmp++;
         if (wire_q[f+16] !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL b2b_idle_after got %b exp %b", wire_q[f+16], 2'b00);
         end
      end
   endtask

   // Bytes 11,22,...,88 at one bit per cycle: 11..55 fit (one popped early),
   // 66,77,88 are dropped.
   task automatic test_overflow();
      int f;
      bit ok;
      int max_lvl;
      logic [7:0] bv;
      reset_dut();
      wire_q.delete();
      max_lvl = 0;
      for (int j = 0; j < 8; j++) begin
         bv = 8'((j + 1) * 17);
         for (int i = 0; i < 8; i++) begin
            bit_stb = 1'b1;
            bit_in  = bv[7-i];
            step();
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
         end
      end
      bit_stb = 1'b0;
      n_cmp++;
      if (max_lvl !== 4) begin
         n_fail++;
         $display("[TB] FAIL ovf_max_level got %0d exp %0d", max_lvl, 4);
      end
      n_cmp++;
      if (overflow !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL ovf_flag got %b exp %b", overflow, 1'b1);
      end
      wait_wire(40, f, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("[TB] FAIL ovf_timeout got %0d exp %0d", wire_q.size(), 40);
      end else begin
         for (int j = 0; j < 5; j++) begin
            bv = 8'((j + 1) * 17);
            n_cmp++;
            if ({wire_frames(f+8*j), wire_byte(f+8*j)} !== {8'h80, bv}) begin
               n_fail++;
               $display("[TB] FAIL ovf_byte%0d got %h exp %h", j, {wire_frames(f+8*j), wire_byte(f+8*j)}, {8'h80, bv});
            end
         end
      end
   endtask

   // Runs straight after the overflow test so overflow starts set.
   task automatic test_abort();
      int f;
      bit ok;
      wire_q.delete();
      send_bits(8'h81, 8);
      send_bits(8'h42, 8);
      wait_wire(4, f, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("[TB] FAIL abort_timeout got %0d exp %0d", wire_q.size(), 4);
      end else begin
         n_cmp++;
         if ({wire_q[f][0], wire_q[f+1][0], wire_q[f+2][0], wire_q[f+3][0], overflow, fifo_level} !== {4'b1000, 1'b1, 3'd1}) begin
            n_fail++;
            $display("[TB] FAIL abort_pre got %b exp %b", {wire_q[f][0], wire_q[f+1][0], wire_q[f+2][0], wire_q[f+3][0], overflow, fifo_level}, {4'b1000, 1'b1, 3'd1});
         end
      end
      enable = 1'b0;
      step();
      n_cmp++;
      if ({ssp_clk, ssp_frame, ssp_din, overflow, fifo_level} !== 7'h00) begin
         n_fail++;
         $display("[TB] FAIL abort_clear got %h exp %h", {ssp_clk, ssp_frame, ssp_din, overflow, fifo_level}, 7'h00);
      end
      send_bits(8'hFF, 8);
      wire_q.delete();
      enable = 1'b1;
      send_bits(8'h55, 8);
      wait_wire(9, f, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("[TB] FAIL abort_resume_timeout got %0d exp %0d", wire_q.size(), 9);
      end else begin
         n_cmp++;
         if ({wire_byte(f), wire_frames(f), wire_q[f+8]} !== {8'h55, 8'h80, 2'b00}) begin
            n_fail++;
            $display("[TB] FAIL abort_resume_55 got %h exp %h", {wire_byte(f), wire_frames(f), wire_q[f+8]}, {8'h55, 8'h80, 2'b00});
         end
      end
   endtask

   task automatic test_async_reset();
      int f;
      bit ok;
      reset_dut();
      wire_q.delete();
      send_bits(8'hFF, 8);
      send_bits(8'hF0, 8);
      wait_wire(1, f, ok);
      n_cmp++;
      if ({ok, ssp_clk, ssp_frame, ssp_din, fifo_level} !== {1'b1, 3'b111, 3'd1}) begin
         n_fail++;
         $display("[TB] FAIL arst_pre got %b exp %b", {ok, ssp_clk, ssp_frame, ssp_din, fifo_level}, {1'b1, 3'b111, 3'd1});
      end
      #2;
      nreset = 1'b0;
      #1;
      n_cmp++;
      if ({ssp_clk, ssp_frame, ssp_din, overflow, fifo_level} !== 7'h00) begin
         n_fail++;
         $display("[TB] FAIL arst_outputs got %h exp %h", {ssp_clk, ssp_frame, ssp_din, overflow, fifo_level}, 7'h00);
      end
      step();
      nreset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_byte_a5();
      test_flush();
      test_back_to_back();
      test_overflow();
      test_abort();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
